// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the
// baud-divider computation used by both the receiver and transmitter.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Clocks per oversample tick; truncated, never below 1.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        int unsigned d;
        d = clk_freq / (baud_rate * UART_OVERSAMPLE);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider producing a one-cycle tick every DIV clocks.
// A synchronous clear restarts the count so the tick phase can be aligned
// to an external event (e.g. a start-bit edge).
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps at DIV-1, restarts on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled 8N1 deserialiser with a valid/ready output.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit between the
// data and stop bits and adds the parity_err pulse output.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq       = 50000000,
    parameter int unsigned uart_baud_rate = 115200,
    parameter int unsigned OVERSAMPLE     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned DIV = uart_div(clk_freq, uart_baud_rate);
    localparam logic [3:0] SC_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      rxs;
    logic                      tick;
    logic                      tick_clr;
    logic                      data_ok;
    uart_state_e               state;
    logic [3:0]                sc;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    // Align the tick phase to the start-bit edge.
    assign tick_clr = (state == IDLE) && !rxs;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign data_ok = !par_bad;
`else
    assign data_ok = 1'b1;
`endif

    // Receive FSM with registered outputs and output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sc        <= 4'd0;
            bit_idx   <= 3'd0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tick) begin
                sc <= sc + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        sc    <= 4'd0;
                        busy  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick && sc == SC_MID) begin
                        if (!rxs) begin
                            state   <= DATA;
                            sc      <= 4'd0;
                            bit_idx <= 3'd0;
                        end else begin
                            // Too short to be a start bit.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick && sc == SC_LAST) begin
                        shift   <= {rxs, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick && sc == SC_LAST) begin
                        if (^{shift, rxs}) begin
                            parity_err <= 1'b1;
                            par_bad    <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick && sc == SC_LAST) begin
                        if (rxs) begin
                            // Return to IDLE at once so a back-to-back start bit is seen.
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (data_ok) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line idles so a stuck-low line is not a start bit.
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    localparam int unsigned LAT_MAX = 171;
`else
    localparam int unsigned LAT_MAX = 155;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned fe_cnt = 0;
    int unsigned ov_cnt = 0;
    int unsigned pe_cnt = 0;
    int unsigned both_cnt = 0;
    int unsigned fall_cnt = 0;
    int unsigned rise_cyc = 0;
    logic        valid_d = 1'b0;

    uart_rx_core #(
        .clk_freq       (16000000),
        .uart_baud_rate (1000000),
        .OVERSAMPLE     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_err && overrun) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
        if (rx_valid && !valid_d) rise_cyc <= cyc;
        if (!rx_valid && valid_d) fall_cnt <= fall_cnt + 1;
        valid_d <= rx_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ready_at: stop-bit clock index at which rx_ready is pulsed (-1 = never).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input int ready_at);
        uart_rxd = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            step(16);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^d) ^ par_flip;
        step(16);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        uart_rxd = stop_bit;
        for (int i = 0; i < 16; i++) begin
            rx_ready = (i == ready_at);
            step(1);
        end
        rx_ready = 1'b0;
        uart_rxd = 1'b1;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    int unsigned c0;
    int unsigned f0;

    initial begin
        // Reset state
        step(3);
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_ovr", overrun, 1'b0);
        rst = 1'b1;
        step(5);

        // 0x55, no consumer
        c0 = cyc;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        check_eq("f55_valid", rx_valid, 1'b1);
        check_eq("f55_data", rx_data, 8'h55);
        check_eq("f55_latency", (rise_cyc - c0) <= LAT_MAX, 1'b1);
        step(20);
        check_eq("f55_held", {rx_valid, rx_data}, {1'b1, 8'h55});
        accept();
        check_eq("f55_accept", rx_valid, 1'b0);

        // 4-clock glitch
        uart_rxd = 1'b0;
        step(4);
        check_eq("glitch_busy_hi", busy, 1'b1);
        uart_rxd = 1'b1;
        step(10);
        check_eq("glitch_busy_lo", busy, 1'b0);
        check_eq("glitch_valid", rx_valid, 1'b0);
        check_eq("glitch_pulses", fe_cnt + ov_cnt, 0);

        // Framing error, break, then recovery
        send_frame(8'hA3, 1'b0, 1'b0, -1);
        uart_rxd = 1'b0;
        step(48);
        uart_rxd = 1'b1;
        step(20);
        check_eq("ferr_count", fe_cnt, 1);
        check_eq("ferr_no_valid", rx_valid, 1'b0);
        check_eq("ferr_idle", busy, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check_eq("rec_data", rx_data, 8'h3C);
        check_eq("rec_valid", rx_valid, 1'b1);
        check_eq("rec_ferr", fe_cnt, 1);
        accept();

        // Back-to-back, overrun
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        check_eq("ovr_data", rx_data, 8'h11);
        check_eq("ovr_valid", rx_valid, 1'b1);
        check_eq("ovr_count", ov_cnt, 1);
        accept();

        // Back-to-back, accept coincides with delivery
        send_frame(8'h11, 1'b1, 1'b0, -1);
        f0 = fall_cnt;
        send_frame(8'h22, 1'b1, 1'b0, 10);
        check_eq("coin_data", rx_data, 8'h22);
        check_eq("coin_valid", rx_valid, 1'b1);
        check_eq("coin_no_ovr", ov_cnt, 1);
        check_eq("coin_no_gap", fall_cnt - f0, 0);

        // Reset during data bit 4 of 0xFF
        uart_rxd = 1'b0;
        step(16);
        uart_rxd = 1'b1;
        step(64 + 8);
        check_eq("mid_busy", busy, 1'b1);
        rst = 1'b0;
        step(2);
        check_eq("mrst_data", rx_data, 8'h00);
        check_eq("mrst_valid", rx_valid, 1'b0);
        check_eq("mrst_busy", busy, 1'b0);
        check_eq("mrst_pulses", {frame_err, overrun}, 2'b00);
        rst = 1'b1;
        step(200);
        check_eq("mrst_no_ff", rx_valid, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        check_eq("post_data", rx_data, 8'h7E);
        check_eq("post_valid", rx_valid, 1'b1);
        accept();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1);
        check_eq("par_ok_data", rx_data, 8'h07);
        check_eq("par_ok_valid", rx_valid, 1'b1);
        check_eq("par_ok_pe", pe_cnt, 0);
        accept();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        step(4);
        check_eq("par_bad_pe", pe_cnt, 1);
        check_eq("par_bad_valid", rx_valid, 1'b0);
`endif

        check_eq("no_coincident_pulses", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
